// File: rtl/baccarat_dealer.sv
// Baccarat round dealer: loads player/dealer cards one step at a time and applies the third-card tableau.
// Optional BACCARAT_TALLY_EN adds saturating win/tie counters (p_wins, d_wins, ties).
module baccarat_dealer #(
  parameter int CARD_W   = 4,
  parameter int MAX_CARD = 13
) (
  input  logic              slow_clock,
  input  logic              reset,
  input  logic              step,
  input  logic [CARD_W-1:0] new_card,
  input  logic [CARD_W-1:0] pscore,
  input  logic [CARD_W-1:0] dscore,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic              done,
  output logic              player_win,
`ifdef BACCARAT_TALLY_EN
  output logic [7:0]        p_wins,
  output logic [7:0]        d_wins,
  output logic [7:0]        ties,
`endif
  output logic              dealer_win
);

  typedef enum logic [2:0] {
    DEAL_P1 = 3'd0,
    DEAL_D1 = 3'd1,
    DEAL_P2 = 3'd2,
    DEAL_D2 = 3'd3,
    PLAYER3 = 3'd4,
    DEALER3 = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            state_reg;
  logic              p_drew_reg;
  logic              legal;
  logic              natural;
  logic              dealer_draw;
  logic [CARD_W-1:0] pv;

  assign legal   = (new_card != '0) && (new_card <= CARD_W'(MAX_CARD));
  assign natural = (pscore >= CARD_W'(8)) || (dscore >= CARD_W'(8));
  assign pv      = (pcard3 >= CARD_W'(10)) ? '0 : pcard3;

  // Banker tableau: depends on whether the player took a third card and its value.
  always_comb begin
    dealer_draw = 1'b0;
    if (!p_drew_reg) begin
      dealer_draw = (dscore <= CARD_W'(5));
    end else begin
      case (dscore)
        CARD_W'(0), CARD_W'(1), CARD_W'(2): dealer_draw = 1'b1;
        CARD_W'(3): dealer_draw = (pv != CARD_W'(8));
        CARD_W'(4): dealer_draw = (pv >= CARD_W'(2)) && (pv <= CARD_W'(7));
        CARD_W'(5): dealer_draw = (pv >= CARD_W'(4)) && (pv <= CARD_W'(7));
        CARD_W'(6): dealer_draw = (pv >= CARD_W'(6)) && (pv <= CARD_W'(7));
        default:    dealer_draw = 1'b0;
      endcase
    end
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_reg  <= DEAL_P1;
      p_drew_reg <= 1'b0;
      done       <= 1'b0;
      pcard1     <= '0;
      pcard2     <= '0;
      pcard3     <= '0;
      dcard1     <= '0;
      dcard2     <= '0;
      dcard3     <= '0;
    end else begin
      case (state_reg)
        DEAL_P1: if (step && legal) begin pcard1 <= new_card; state_reg <= DEAL_D1; end
        DEAL_D1: if (step && legal) begin dcard1 <= new_card; state_reg <= DEAL_P2; end
        DEAL_P2: if (step && legal) begin pcard2 <= new_card; state_reg <= DEAL_D2; end
        DEAL_D2: if (step && legal) begin dcard2 <= new_card; state_reg <= PLAYER3; end
        PLAYER3: if (step) begin
          if (natural) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else if (pscore <= CARD_W'(5)) begin
            if (legal) begin
              pcard3     <= new_card;
              p_drew_reg <= 1'b1;
              state_reg  <= DEALER3;
            end
          end else begin
            p_drew_reg <= 1'b0;
            state_reg  <= DEALER3;
          end
        end
        DEALER3: if (step) begin
          if (!dealer_draw) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else if (legal) begin
            dcard3    <= new_card;
            state_reg <= DONE;
            done      <= 1'b1;
          end
        end
        DONE: if (step) begin
          state_reg  <= DEAL_P1;
          done       <= 1'b0;
          p_drew_reg <= 1'b0;
          pcard1     <= '0;
          pcard2     <= '0;
          pcard3     <= '0;
          dcard1     <= '0;
          dcard2     <= '0;
          dcard3     <= '0;
        end
        default: begin
          state_reg <= DEAL_P1;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign player_win = done && (pscore > dscore);
  assign dealer_win = done && (dscore > pscore);

`ifdef BACCARAT_TALLY_EN
  logic [2:0] outcome;
  logic [7:0] tally_reg [3];

  // Index 0: player win, 1: dealer win, 2: tie.
  assign outcome = {(pscore == dscore), (dscore > pscore), (pscore > dscore)};

  for (genvar gi = 0; gi < 3; gi++) begin : g_tally
    always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
        tally_reg[gi] <= '0;
      end else if ((state_reg == DONE) && step && outcome[gi] && (tally_reg[gi] != 8'hFF)) begin
        tally_reg[gi] <= tally_reg[gi] + 8'd1;
      end
    end
  end

  assign p_wins = tally_reg[0];
  assign d_wins = tally_reg[1];
  assign ties   = tally_reg[2];
`endif

endmodule

// File: tb/tb_baccarat_dealer.sv
// Scoreboard bench for baccarat_dealer: a round-level Baccarat model predicts final hands and outcome.
module tb_baccarat_dealer;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] new_card;
  logic [3:0] pscore, dscore;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic       done, player_win, dealer_win;
`ifdef BACCARAT_TALLY_EN
  logic [7:0] p_wins, d_wins, ties;
  int         exp_pw = 0, exp_dw = 0, exp_tie = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [23:0] cards;   // {p1,p2,p3,d1,d2,d3}
    bit          pw;
    bit          dw;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  baccarat_dealer #(.CARD_W(4), .MAX_CARD(13)) dut (
    .slow_clock(clk),
    .reset(reset),
    .step(step),
    .new_card(new_card),
    .pscore(pscore),
    .dscore(dscore),
    .pcard1(pcard1),
    .pcard2(pcard2),
    .pcard3(pcard3),
    .dcard1(dcard1),
    .dcard2(dcard2),
    .dcard3(dcard3),
    .done(done),
    .player_win(player_win),
`ifdef BACCARAT_TALLY_EN
    .p_wins(p_wins),
    .d_wins(d_wins),
    .ties(ties),
`endif
    .dealer_win(dealer_win)
  );

  function automatic int cval(input int c);
    return (c >= 10) ? 0 : c;
  endfunction

  function automatic int hand(input int a, input int b, input int c);
    return (cval(a) + cval(b) + cval(c)) % 10;
  endfunction

  // Downstream scorehand instances.
  always_comb begin
    pscore = 4'(hand(int'(pcard1), int'(pcard2), int'(pcard3)));
    dscore = 4'(hand(int'(dcard1), int'(dcard2), int'(dcard3)));
  end

  function automatic bit is_legal(input int c);
    return (c >= 1) && (c <= 13);
  endfunction

  // Banker tableau as a row of "draw" bits indexed by the player's third-card value.
  function automatic bit tableau(input int d, input int v);
    logic [9:0] row;
    case (d)
      0, 1, 2: row = 10'b11_1111_1111;
      3:       row = 10'b10_1111_1111;
      4:       row = 10'b00_1111_1100;
      5:       row = 10'b00_1111_0000;
      6:       row = 10'b00_1100_0000;
      default: row = 10'b00_0000_0000;
    endcase
    return row[v];
  endfunction

  function automatic int rand_card();
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 2))
        0:       return 0;
        1:       return 14;
        default: return 15;
      endcase
    end
    return int'($urandom_range(1, 13));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Plays one round abstractly; returns the card offers to present and the expected result.
  task automatic build_round(input int dl[$], output int offers[$], output exp_t e);
    int h[6];      // p1,d1,p2,d2,p3,d3
    int idx, c, ps, ds;
    bit pdrew;
    idx = 0;
    offers = {};
    foreach (h[k]) h[k] = 0;
    for (int slot = 0; slot < 4; slot++) begin
      do begin
        c = (idx < dl.size()) ? dl[idx] : rand_card();
        idx++;
        offers.push_back(c);
      end while (!is_legal(c));
      h[slot] = c;
    end
    ps = hand(h[0], h[2], 0);
    ds = hand(h[1], h[3], 0);
    pdrew = 0;
    if (ps >= 8 || ds >= 8) begin
      c = (idx < dl.size()) ? dl[idx] : rand_card();
      idx++;
      offers.push_back(c);
    end else begin
      if (ps <= 5) begin
        do begin
          c = (idx < dl.size()) ? dl[idx] : rand_card();
          idx++;
          offers.push_back(c);
        end while (!is_legal(c));
        h[4] = c;
        pdrew = 1;
      end else begin
        c = (idx < dl.size()) ? dl[idx] : rand_card();
        idx++;
        offers.push_back(c);
      end
      if (pdrew ? tableau(ds, cval(h[4])) : (ds <= 5)) begin
        do begin
          c = (idx < dl.size()) ? dl[idx] : rand_card();
          idx++;
          offers.push_back(c);
        end while (!is_legal(c));
        h[5] = c;
      end else begin
        c = (idx < dl.size()) ? dl[idx] : rand_card();
        idx++;
        offers.push_back(c);
      end
    end
    ps = hand(h[0], h[2], h[4]);
    ds = hand(h[1], h[3], h[5]);
    e.cards = {4'(h[0]), 4'(h[2]), 4'(h[4]), 4'(h[1]), 4'(h[3]), 4'(h[5])};
    e.pw = (ps > ds);
    e.dw = (ds > ps);
  endtask

  task automatic do_step(input int c);
    @(negedge clk);
    step = 1'b1;
    new_card = 4'(c);
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic play_round(input int dl[$]);
    int   offers[$];
    exp_t e;
    build_round(dl, offers, e);
    exp_q.push_back(e);
    foreach (offers[k]) do_step(offers[k]);
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("round_done_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
`ifdef BACCARAT_TALLY_EN
    if (e.pw) exp_pw++;
    else if (e.dw) exp_dw++;
    else exp_tie++;
`endif
    do_step(rand_card());
    check("clear_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 32'd0);
    check("clear_done", 32'(done), 32'd0);
  endtask

  // Monitor: compares each completed round against the oldest prediction.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected no round pending");
      end else begin
        e = exp_q.pop_front();
        check("final_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 32'(e.cards));
        check("player_win", 32'(player_win), 32'(e.pw));
        check("dealer_win", 32'(dealer_win), 32'(e.dw));
      end
    end
    done_q <= done;
  end

  initial begin
    int dl[$];
    reset = 1'b1;
    step = 1'b0;
    new_card = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 32'd0);
    check("reset_done", 32'({done, player_win, dealer_win}), 32'd0);
    reset = 1'b0;

    // Reach DEALER3 (player stands), then pulse reset between clock edges.
    dl = '{3, 1, 3, 4, 7};
    foreach (dl[k]) do_step(dl[k]);
    check("pre_reset_pcard1", 32'(pcard1), 32'd3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    #1 reset = 1'b0;

    dl = '{4, 2, 5, 3, 5};              play_round(dl);  // natural
    dl = '{2, 3, 1, 4, 6, 9};           play_round(dl);  // player draws, dealer 7 stands
    dl = '{2, 6, 3, 10, 12, 8};         play_round(dl);  // face third card, dealer 6 stands
    dl = '{3, 1, 3, 4, 7, 1};           play_round(dl);  // player stands, dealer draws, tie
    dl = '{5, 0, 14, 7, 2, 9, 4, 2};    play_round(dl);  // illegal cards in DEAL_D1
    dl = '{};
    repeat (60) play_round(dl);

`ifdef BACCARAT_TALLY_EN
    check("tally_p_wins", 32'(p_wins), 32'(exp_pw));
    check("tally_d_wins", 32'(d_wins), 32'(exp_dw));
    check("tally_ties", 32'(ties), 32'(exp_tie));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baccarat_dealer.md
Name: baccarat_dealer

Overview:
- Sequential dealing controller for one Baccarat round.
- Takes one card per `step` pulse from the upstream card source and loads it into the player or dealer card registers.
- Feeds those registers to two downstream `scorehand` instances and reads back their totals.
- Applies the natural and third-card rules, then flags the round outcome.

Parameters:
- CARD_W, 4, width of card codes and of score totals.
- MAX_CARD, 13, highest legal card code; legal codes are 1..MAX_CARD (11-13 are faces, valued 0 by `scorehand`).

Ports:
- slow_clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- step  input  1  advance request; one state advance per cycle in which it is high.
- new_card  input  CARD_W  card offered by the upstream source; sampled on `step`.
- pscore  input  CARD_W  player total from `scorehand`(pcard1,pcard2,pcard3).
- dscore  input  CARD_W  dealer total from `scorehand`(dcard1,dcard2,dcard3).
- pcard1, pcard2, pcard3  output  CARD_W each  player card registers.
- dcard1, dcard2, dcard3  output  CARD_W each  dealer card registers.
- done  output  1  round complete.
- player_win  output  1  done and pscore > dscore.
- dealer_win  output  1  done and dscore > pscore.

Behaviour:
- Reset is asynchronous, active-high. While it is asserted, all six card registers are 0, `p_drew` is 0 and state is DEAL_P1. `done`, `player_win` and `dealer_win` are therefore 0.
- Clock domain: slow_clock only. pscore/dscore are combinational from the card registers and are valid one cycle after a load.
- A card is legal when new_card is in 1..MAX_CARD.
- Card-load states: on step with a legal card, load it and advance. On step with an illegal card (0 or >MAX_CARD), hold state and registers. Without step, hold.
  - DEAL_P1 loads pcard1, then DEAL_D1.
  - DEAL_D1 loads dcard1, then DEAL_P2.
  - DEAL_P2 loads pcard2, then DEAL_D2.
  - DEAL_D2 loads dcard2, then PLAYER3.
- PLAYER3 on step:
  - Natural (pscore>=8 or dscore>=8): go to DONE; no load; new_card ignored.
  - Else pscore<=5: load pcard3 from a legal new_card, set p_drew=1, go to DEALER3. An illegal card holds the state.
  - Else (6 or 7): player stands; p_drew=0; go to DEALER3 with no load.
- DEALER3 on step: let v = pcard3 value (0 if pcard3>=10, else pcard3). The dealer draws when:
  - p_drew=0: dscore<=5.
  - p_drew=1, dscore 0-2: always.
  - p_drew=1, dscore 3: v != 8.
  - p_drew=1, dscore 4: v in 2..7.
  - p_drew=1, dscore 5: v in 4..7.
  - p_drew=1, dscore 6: v in 6..7.
  - p_drew=1, dscore 7: never.
  - Draw: load dcard3 from a legal card, then go to DONE (an illegal card holds). Stand: go to DONE with no load.
- DONE:
  - done=1. player_win and dealer_win are combinational compares of the current pscore/dscore, so they are valid from the cycle after a dcard3 load.
  - Tie: done=1 with both win flags 0.
  - Step clears all card registers and p_drew, and returns to DEAL_P1; no card is taken that cycle.
- Reset mid-round immediately clears everything, regardless of state or step.
- Unused states decode to DEAL_P1.

Optional Feature:
- Macro: BACCARAT_TALLY_EN.
- Defined: adds outputs p_wins, d_wins, ties (8 bits each, saturating at 255).
  - Each increments once per round, in the cycle where DONE is exited by step, according to the outcome.
  - Cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Natural: deal P1=4, D1=2, P2=5, D2=3, then step in PLAYER3 -> DONE with pcard3=dcard3=0, pscore=9, player_win=1, dealer_win=0.
- Player draws, dealer 7 stands: P1=2, D1=3, P2=1, D2=4, third card 6 -> pcard3=6, pscore=9, dscore=7, dcard3=0, player_win=1.
- Face as third card: P1=2, D1=6, P2=3, D2=10, player third card 12 (v=0) -> dealer 6 stands, dcard3=0, pscore=5, dscore=6, dealer_win=1.
- Player stands, dealer draws: P1=3, D1=1, P2=3, D2=4; step in PLAYER3 -> no pcard3; dealer third card 1 -> dcard3=1, pscore=6, dscore=6, done=1, both win flags 0 (tie).
- Illegal cards: in DEAL_D1 step with new_card=0, then 14 -> dcard1 stays 0 and state holds; step with 7 -> dcard1=7, state DEAL_P2.
- Async reset pulse in DEALER3 without a clock edge -> all cards 0 immediately, done=0; after release, the first step loads pcard1.
